// File: rtl/data_ram_pkg.sv
// Shared constants and types for the data RAM block.
package data_ram_pkg;

    // Default log2 of the number of 32-bit words stored.
    localparam int DataMemNumLog2 = 10;

    // Reset level for this block (active-low).
    localparam logic RstEnable = 1'b0;

    // Store-request encodings from the memory stage.
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // Clearing sweep / normal operation.
    typedef enum logic {
        DRAM_INIT  = 1'b0,
        DRAM_READY = 1'b1
    } dram_state_e;

endpackage

// File: rtl/dram_lane_align.sv
// Byte-lane alignment for the data RAM: shifts the low-aligned store
// byte-select and data up to the addressed offset, flags accesses that
// spill past the word, and right-justifies read data by the same offset.
module dram_lane_align (
    input  logic [1:0]  off,
    input  logic [3:0]  sel,
    input  logic [31:0] data,
    input  logic [31:0] rd_word,
    output logic [7:0]  sel_w,
    output logic [31:0] data_sh,
    output logic        misaligned,
    output logic [31:0] rd_data
);

    logic [4:0] bit_sh;

    // Offset in bits; lanes shifted past bit 31 are the spill-over.
    always_comb begin
        bit_sh     = {off, 3'b000};
        sel_w      = {4'b0000, sel} << off;
        data_sh    = data << bit_sh;
        misaligned = |sel_w[7:4];
        rd_data    = rd_word >> bit_sh;
    end

endmodule

// File: rtl/data_ram.sv
// Data RAM behind the memory-access stage: byte-lane stores, right-justified
// combinational loads, post-reset clearing sweep, misalignment reporting and
// a saturating committed-store counter.
module data_ram
    import data_ram_pkg::*;
#(
    parameter int DATA_MEM_NUM_LOG2 = DataMemNumLog2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_we_i,
    input  logic [3:0]                   mem_sel_i,
    input  logic [DATA_MEM_NUM_LOG2+1:0] mem_addr_i,
    input  logic [31:0]                  mem_data_i,
    output logic [31:0]                  mem_data_o,
    output logic                         init_busy_o,
    output logic                         misalign_o,
    output logic                         err_o,
    output logic [DATA_MEM_NUM_LOG2+1:0] err_addr_o,
    output logic [15:0]                  wr_count_o
);

    localparam int N     = DATA_MEM_NUM_LOG2;
    localparam int AW    = DATA_MEM_NUM_LOG2 + 2;
    localparam int DEPTH = 1 << N;

    localparam logic [N-1:0] PtrOne   = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] PtrLast  = {N{1'b1}};
    localparam logic [15:0]  CountMax = 16'hFFFF;

    logic [31:0] mem [DEPTH];

    dram_state_e state_q, state_d;
    logic [N-1:0] clr_ptr;

    logic [N-1:0] idx;
    logic [1:0]   off;
    logic [7:0]   sel_w;
    logic [31:0]  data_sh;
    logic         misaligned;
    logic [31:0]  rd_data;

    logic         clr_en;
    logic         commit;
    logic         reject;

    assign idx = mem_addr_i[AW-1:2];
    assign off = mem_addr_i[1:0];

    dram_lane_align u_align (
        .off        (off),
        .sel        (mem_sel_i),
        .data       (mem_data_i),
        .rd_word    (mem[idx]),
        .sel_w      (sel_w),
        .data_sh    (data_sh),
        .misaligned (misaligned),
        .rd_data    (rd_data)
    );

    // State register: reset always restarts the sweep.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) state_q <= DRAM_INIT;
        else                  state_q <= state_d;
    end

    // Next state: leave INIT once the last word has been cleared; READY holds.
    always_comb begin
        state_d = state_q;
        case (state_q)
            DRAM_INIT:  if (clr_ptr == PtrLast) state_d = DRAM_READY;
            DRAM_READY: state_d = DRAM_READY;
            default:    state_d = DRAM_INIT;
        endcase
    end

    // Outputs/strobes: stores are only honoured in READY.
    always_comb begin
        init_busy_o = 1'b0;
        clr_en      = 1'b0;
        commit      = 1'b0;
        reject      = 1'b0;
        mem_data_o  = 32'h0;
        case (state_q)
            DRAM_INIT: begin
                init_busy_o = 1'b1;
                clr_en      = 1'b1;
            end
            DRAM_READY: begin
                commit     = (mem_we_i == WriteEnable) && (|sel_w[3:0]) && !misaligned;
                reject     = (mem_we_i == WriteEnable) && misaligned;
                mem_data_o = rd_data;
            end
            default: begin
                init_busy_o = 1'b1;
            end
        endcase
    end

    // Sweep pointer: walks every word once per reset.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) clr_ptr <= '0;
        else if (clr_en)      clr_ptr <= clr_ptr + PtrOne;
    end

    // Array: sweep zeroing, otherwise per-lane store of the shifted data.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem[clr_ptr] <= 32'h0;
        end else if (commit) begin
            for (int j = 0; j < 4; j++) begin
                if (sel_w[j]) mem[idx][8*j +: 8] <= data_sh[8*j +: 8];
            end
        end
    end

    // Committed-store counter, saturating.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable)                   wr_count_o <= 16'h0;
        else if (commit && wr_count_o != CountMax) wr_count_o <= wr_count_o + 16'd1;
    end

    // Misalignment: one-cycle pulse per rejected store, sticky flag, first address kept.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RstEnable) begin
            misalign_o <= 1'b0;
            err_o      <= 1'b0;
            err_addr_o <= '0;
        end else begin
            misalign_o <= reject;
            if (reject) begin
                err_o <= 1'b1;
                if (!err_o) err_addr_o <= mem_addr_i;
            end
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Self-checking bench for data_ram (N=4): table vectors for the directed
// cases, randomized stores/loads against a byte-array reference model,
// and reset/sweep corner cases.
module tb_data_ram;

    localparam int N  = 4;
    localparam int AW = N + 2;
    localparam int NB = 4 << N;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          mem_we_i = 1'b0;
    logic [3:0]    mem_sel_i = 4'h0;
    logic [AW-1:0] mem_addr_i = '0;
    logic [31:0]   mem_data_i = 32'h0;
    logic [31:0]   mem_data_o;
    logic          init_busy_o;
    logic          misalign_o;
    logic          err_o;
    logic [AW-1:0] err_addr_o;
    logic [15:0]   wr_count_o;

    data_ram #(.DATA_MEM_NUM_LOG2(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_we_i    (mem_we_i),
        .mem_sel_i   (mem_sel_i),
        .mem_addr_i  (mem_addr_i),
        .mem_data_i  (mem_data_i),
        .mem_data_o  (mem_data_o),
        .init_busy_o (init_busy_o),
        .misalign_o  (misalign_o),
        .err_o       (err_o),
        .err_addr_o  (err_addr_o),
        .wr_count_o  (wr_count_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: flat byte array plus the sticky error and counter.
    logic [7:0]    mb [NB];
    logic          m_err;
    logic [AW-1:0] m_eaddr;
    logic [15:0]   m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [3:0] sel);
        case (sel)
            4'b0001: return 1;
            4'b0011: return 2;
            4'b1111: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) mb[i] = 8'h0;
        m_err = 1'b0; m_eaddr = '0; m_cnt = 16'h0;
    endtask

    // Load: bytes from the address to the end of its word, zero above.
    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        logic [31:0] r = 32'h0;
        int o = int'(a[1:0]);
        for (int k = 0; k < 4 - o; k++) r = r | (32'(mb[int'(a) + k]) << (8 * k));
        return r;
    endfunction

    // Store: an access of n bytes at offset o is rejected if it crosses the word.
    task automatic model_apply(input logic we, input logic [3:0] sel, input logic [AW-1:0] a,
                               input logic [31:0] d, output logic mis);
        int n = nbytes(sel);
        int o = int'(a[1:0]);
        mis = 1'b0;
        if (we && n > 0) begin
            if (o + n > 4) begin
                mis = 1'b1;
                if (!m_err) begin m_err = 1'b1; m_eaddr = a; end
            end else begin
                for (int k = 0; k < n; k++) mb[int'(a) + k] = d[8*k +: 8];
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            end
        end
    endtask

    // Counts cycles of init_busy_o from the current point, bounded.
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (init_busy_o && cnt < 100) begin
            chk("init_rd_zero", mem_data_o, 32'h0);
            @(posedge clk); #1;
            cnt++;
        end
    endtask

    typedef struct {
        logic          we;
        logic [3:0]    sel;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [31:0]   rd;
        logic          mis;
        logic          err;
        logic [AW-1:0] eaddr;
        logic [15:0]   cnt;
    } vec_t;

    vec_t tbl [14];

    initial begin
        int cnt;
        logic mis;

        tbl[0]  = '{1'b1, 4'hF, 6'h08, 32'hDEADBEEF, 32'h00000000, 1'b0, 1'b0, 6'h00, 16'd1};
        tbl[1]  = '{1'b0, 4'h0, 6'h08, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'h00, 16'd1};
        tbl[2]  = '{1'b0, 4'h0, 6'h09, 32'h0,        32'h00DEADBE, 1'b0, 1'b0, 6'h00, 16'd1};
        tbl[3]  = '{1'b0, 4'h0, 6'h0B, 32'h0,        32'h000000DE, 1'b0, 1'b0, 6'h00, 16'd1};
        tbl[4]  = '{1'b1, 4'h1, 6'h0A, 32'h000000AA, 32'h0000DEAD, 1'b0, 1'b0, 6'h00, 16'd2};
        tbl[5]  = '{1'b0, 4'h0, 6'h08, 32'h0,        32'hDEAABEEF, 1'b0, 1'b0, 6'h00, 16'd2};
        tbl[6]  = '{1'b1, 4'h3, 6'h0A, 32'h00001234, 32'h0000DEAA, 1'b0, 1'b0, 6'h00, 16'd3};
        tbl[7]  = '{1'b0, 4'h0, 6'h08, 32'h0,        32'h1234BEEF, 1'b0, 1'b0, 6'h00, 16'd3};
        tbl[8]  = '{1'b1, 4'h3, 6'h0B, 32'h00005678, 32'h00000012, 1'b1, 1'b1, 6'h0B, 16'd3};
        tbl[9]  = '{1'b1, 4'hF, 6'h06, 32'h99999999, 32'h00000000, 1'b1, 1'b1, 6'h0B, 16'd3};
        tbl[10] = '{1'b0, 4'h0, 6'h08, 32'h0,        32'h1234BEEF, 1'b0, 1'b1, 6'h0B, 16'd3};
        tbl[11] = '{1'b1, 4'h0, 6'h08, 32'hFFFFFFFF, 32'h1234BEEF, 1'b0, 1'b1, 6'h0B, 16'd3};
        tbl[12] = '{1'b1, 4'hF, 6'h10, 32'h11111111, 32'h00000000, 1'b0, 1'b1, 6'h0B, 16'd4};
        tbl[13] = '{1'b0, 4'h0, 6'h10, 32'h0,        32'h11111111, 1'b0, 1'b1, 6'h0B, 16'd4};

        model_reset();

        // Reset state.
        #12;
        chk("rst_busy", 32'(init_busy_o), 32'h1);
        chk("rst_mis", 32'(misalign_o), 32'h0);
        chk("rst_err", 32'(err_o), 32'h0);
        chk("rst_eaddr", 32'(err_addr_o), 32'h0);
        chk("rst_cnt", 32'(wr_count_o), 32'h0);

        // Release reset mid-cycle, with a store held during the sweep.
        @(posedge clk); #1;
        rst = 1'b1;
        mem_we_i = 1'b1; mem_sel_i = 4'hF; mem_addr_i = 6'h00; mem_data_i = 32'hFFFFFFFF;
        count_busy(cnt);
        mem_we_i = 1'b0; mem_sel_i = 4'h0;
        chk("init_cycles", 32'(cnt), 32'd16);
        chk("init_cnt", 32'(wr_count_o), 32'h0);
        chk("init_err", 32'(err_o), 32'h0);
        for (int w = 0; w < 16; w++) begin
            mem_addr_i = AW'(w * 4); #1;
            chk("clear_word", mem_data_o, 32'h0);
        end

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            mem_we_i = tbl[i].we; mem_sel_i = tbl[i].sel;
            mem_addr_i = tbl[i].addr; mem_data_i = tbl[i].data;
            model_apply(tbl[i].we, tbl[i].sel, tbl[i].addr, tbl[i].data, mis);
            #1;
            chk($sformatf("tbl%0d_rd", i), mem_data_o, tbl[i].rd);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_mis", i), 32'(misalign_o), 32'(tbl[i].mis));
            chk($sformatf("tbl%0d_err", i), 32'(err_o), 32'(tbl[i].err));
            chk($sformatf("tbl%0d_eaddr", i), 32'(err_addr_o), 32'(tbl[i].eaddr));
            chk($sformatf("tbl%0d_cnt", i), 32'(wr_count_o), 32'(tbl[i].cnt));
        end

        // Randomized stores/loads against the model.
        for (int i = 0; i < 300; i++) begin
            logic          we;
            logic [3:0]    sel;
            logic [AW-1:0] a;
            logic [31:0]   d;
            logic [3:0]    sels [4];
            sels[0] = 4'h0; sels[1] = 4'h1; sels[2] = 4'h3; sels[3] = 4'hF;
            we  = 1'($urandom_range(0, 1));
            sel = sels[$urandom_range(0, 3)];
            a   = AW'($urandom);
            d   = $urandom;
            mem_we_i = we; mem_sel_i = sel; mem_addr_i = a; mem_data_i = d;
            #1;
            chk("rnd_rd", mem_data_o, model_read(a));
            model_apply(we, sel, a, d, mis);
            @(posedge clk); #1;
            chk("rnd_mis", 32'(misalign_o), 32'(mis));
            chk("rnd_err", 32'(err_o), 32'(m_err));
            chk("rnd_eaddr", 32'(err_addr_o), 32'(m_eaddr));
            chk("rnd_cnt", 32'(wr_count_o), 32'(m_cnt));
        end
        mem_we_i = 1'b0; mem_sel_i = 4'h0;

        // Reset mid-sweep restarts the clearing from word 0.
        rst = 1'b0; #1;
        chk("rst2_err", 32'(err_o), 32'h0);
        chk("rst2_cnt", 32'(wr_count_o), 32'h0);
        chk("rst2_mis", 32'(misalign_o), 32'h0);
        chk("rst2_busy", 32'(init_busy_o), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (7) begin @(posedge clk); #1; end
        rst = 1'b0; #1;
        chk("rst3_err", 32'(err_o), 32'h0);
        chk("rst3_cnt", 32'(wr_count_o), 32'h0);
        chk("rst3_mis", 32'(misalign_o), 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;
        count_busy(cnt);
        chk("resweep_cycles", 32'(cnt), 32'd16);
        model_reset();
        for (int w = 0; w < 16; w++) begin
            mem_addr_i = AW'(w * 4); #1;
            chk("reclear_word", mem_data_o, model_read(mem_addr_i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

endmodule
